mem_arbiter: RTL and testbench

- Sits directly upstream of main memory and drives the consumer side of its line-wide load/store bus.
- Arbitrates between the instruction cache (line loads only) and the data cache (line loads and line stores).
- Holds one memory transaction outstanding at a time: registers the granted request, keeps it stable until memory acknowledges, then returns data and a one-cycle ready pulse to the winner.
- Enforces the request-drop rule memory needs to avoid re-triggering.

---
 rtl/constants_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared widths and enumerations for the memory-side arbitration logic.
package constants_pkg;

    localparam int unsigned PHY_LEN = 20;
    localparam int unsigned MBLEN   = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IC_BUSY = 3'd1,
        DC_LD   = 3'd2,
        DC_ST   = 3'd3,
        RESP    = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between icache and dcache, alternating on conflict.
module mem_arb_pick
    import constants_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant
);

    always_comb begin
        grant_valid = ic_req | dc_req;
        grant       = GNT_IC;
        if (ic_req && dc_req) begin
            grant = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (dc_req) begin
            grant = GNT_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding line arbiter between icache/dcache and main memory.
module mem_arbiter
    import constants_pkg::*;
#(
    parameter int unsigned ADDR_W = PHY_LEN,
    parameter int unsigned LINE_W = MBLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_data,
    output logic              ic_ready,
    input  logic              dc_ldp,
    input  logic              dc_srp,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_srData,
    output logic [LINE_W-1:0] dc_ldData,
    output logic              dc_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ldp,
    output logic              mem_srp,
    output logic [LINE_W-1:0] mem_srData,
    input  logic [LINE_W-1:0] mem_ldData,
    input  logic              mem_ldr,
    input  logic              mem_srr
);

    arb_state_t        r_state;
    grant_t            r_last_grant;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_ldp;
    logic              r_mem_srp;
    logic [LINE_W-1:0] r_mem_srData;
    logic [LINE_W-1:0] r_ic_data;
    logic [LINE_W-1:0] r_dc_ldData;
    logic              r_ic_ready;
    logic              r_dc_ready;

    logic   w_dc_req;
    logic   w_grant_valid;
    grant_t w_grant;

    assign w_dc_req = dc_ldp | dc_srp;

    mem_arb_pick u_pick (
        .ic_req      (ic_req),
        .dc_req      (w_dc_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_IC;
            r_mem_addr   <= '0;
            r_mem_ldp    <= 1'b0;
            r_mem_srp    <= 1'b0;
            r_mem_srData <= '0;
            r_ic_data    <= '0;
            r_dc_ldData  <= '0;
            r_ic_ready   <= 1'b0;
            r_dc_ready   <= 1'b0;
        end else begin
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant;
                        if (w_grant == GNT_IC) begin
                            r_mem_addr <= ic_addr;
                            r_mem_ldp  <= 1'b1;
                            r_state    <= IC_BUSY;
                        end else if (dc_srp) begin
                            // A simultaneous load+store request is served as a store.
                            r_mem_addr   <= dc_addr;
                            r_mem_srData <= dc_srData;
                            r_mem_srp    <= 1'b1;
                            r_state      <= DC_ST;
                        end else begin
                            r_mem_addr <= dc_addr;
                            r_mem_ldp  <= 1'b1;
                            r_state    <= DC_LD;
                        end
                    end
                end
                IC_BUSY: begin
                    if (mem_ldr) begin
                        r_ic_data  <= mem_ldData;
                        r_mem_ldp  <= 1'b0;
                        r_ic_ready <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                DC_LD: begin
                    if (mem_ldr) begin
                        r_dc_ldData <= mem_ldData;
                        r_mem_ldp   <= 1'b0;
                        r_dc_ready  <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                DC_ST: begin
                    if (mem_srr) begin
                        r_mem_srp  <= 1'b0;
                        r_dc_ready <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                // Requests are ignored here so the client gets a cycle to drop them.
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dc_ldp && dc_srp))
                else $warning("mem_arbiter: dcache load and store requested together");
            assert (!((r_state == IDLE || r_state == RESP) && (mem_ldr || mem_srr)))
                else $warning("mem_arbiter: memory ack outside a transaction ignored");
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_ldp    = r_mem_ldp;
    assign mem_srp    = r_mem_srp;
    assign mem_srData = r_mem_srData;
    assign ic_data    = r_ic_data;
    assign dc_ldData  = r_dc_ldData;
    assign ic_ready   = r_ic_ready;
    assign dc_ready   = r_dc_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple 8-cycle line memory model.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req = 1'b0;
    logic [19:0]  ic_addr = '0;
    logic [127:0] ic_data;
    logic         ic_ready;
    logic         dc_ldp = 1'b0;
    logic         dc_srp = 1'b0;
    logic [19:0]  dc_addr = '0;
    logic [127:0] dc_srData = '0;
    logic [127:0] dc_ldData;
    logic         dc_ready;
    logic [19:0]  mem_addr;
    logic         mem_ldp;
    logic         mem_srp;
    logic [127:0] mem_srData;
    logic [127:0] mem_ldData;
    logic         mem_ldr;
    logic         mem_srr;

    logic         inj_ldr = 1'b0;
    logic [127:0] mem_line [16];
    logic         m_loaded = 1'b0;
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    int           accesses = 0;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] STORE_D = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D;
    localparam logic [127:0] STORE_X = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_data    (ic_data),
        .ic_ready   (ic_ready),
        .dc_ldp     (dc_ldp),
        .dc_srp     (dc_srp),
        .dc_addr    (dc_addr),
        .dc_srData  (dc_srData),
        .dc_ldData  (dc_ldData),
        .dc_ready   (dc_ready),
        .mem_addr   (mem_addr),
        .mem_ldp    (mem_ldp),
        .mem_srp    (mem_srp),
        .mem_srData (mem_srData),
        .mem_ldData (mem_ldData),
        .mem_ldr    (mem_ldr),
        .mem_srr    (mem_srr)
    );

    function automatic logic [127:0] line_init(input int i);
        return {4{32'hC0DE0000 + i}};
    endfunction

    // Memory: acks 8 cycles after first seeing a request, waits for the drop before re-arming.
    assign mem_ldData = mem_line[mem_addr[7:4]];
    assign mem_ldr    = (mem_ldp && m_cnt == 8 && !m_done) || inj_ldr;
    assign mem_srr    = mem_srp && m_cnt == 8 && !m_done;

    always @(posedge clk) begin
        if (!m_loaded) begin
            for (int i = 0; i < 16; i++) mem_line[i] <= line_init(i);
            m_loaded <= 1'b1;
        end
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if ((mem_ldp || mem_srp) && !m_done) begin
            if (m_cnt == 8) begin
                m_done   <= 1'b1;
                m_cnt    <= 0;
                accesses <= accesses + 1;
                if (mem_srp) mem_line[mem_addr[7:4]] <= mem_srData;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (!(mem_ldp || mem_srp)) begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request, waits for a ready pulse, then checks the pulse is one cycle long.
    task automatic do_txn(input logic ic, input logic ld, input logic st,
                          input logic [19:0] a_ic, input logic [19:0] a_dc,
                          input logic [127:0] wd, input logic drop,
                          output logic got_ic, output logic got_dc,
                          output logic [127:0] rd, output int lat,
                          output logic stable, output logic req1);
        logic [19:0]  a0;
        logic [127:0] d0;
        ic_req = ic; dc_ldp = ld; dc_srp = st;
        ic_addr = a_ic; dc_addr = a_dc; dc_srData = wd;
        got_ic = 0; got_dc = 0; rd = '0; lat = -1; stable = 1; req1 = 0;
        a0 = '0; d0 = '0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (ic_ready || dc_ready) begin
                got_ic = ic_ready;
                got_dc = dc_ready;
                rd     = ic_ready ? ic_data : dc_ldData;
                lat    = c;
                if (mem_ldp || mem_srp) stable = 0;
                break;
            end
            if (c == 1) begin
                req1 = mem_ldp | mem_srp;
                a0   = mem_addr;
                d0   = mem_srData;
            end else if (mem_addr !== a0 || mem_srData !== d0 || !(mem_ldp | mem_srp)) begin
                stable = 0;
            end
        end
        if (drop) begin
            ic_req = 0; dc_ldp = 0; dc_srp = 0;
        end
        step();
        chk("ready_one_cycle", {126'd0, ic_ready, dc_ready}, 128'd0);
    endtask

    typedef struct {
        logic         ic;
        logic         ld;
        logic         st;
        logic [19:0]  a_ic;
        logic [19:0]  a_dc;
        logic [127:0] wd;
        logic         e_ic;
        logic         e_dc;
        logic         chk_d;
        logic [127:0] ed;
    } vec_t;

    vec_t         vecs [6];
    logic         g_ic, g_dc, stb, r1;
    logic [127:0] rdat;
    int           lat;
    int           acc0;
    int           seen_rdy;
    int           seen_req;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 20'h00010, 20'h0, '0,      1'b1, 1'b0, 1'b1, line_init(1)};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 20'h0, 20'h00020, STORE_D, 1'b0, 1'b1, 1'b0, '0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 20'h0, 20'h00020, '0,      1'b0, 1'b1, 1'b1, STORE_D};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 20'h00020, 20'h0, '0,      1'b1, 1'b0, 1'b1, STORE_D};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 20'h0, 20'h00050, '0,      1'b0, 1'b1, 1'b1, line_init(5)};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 20'h000F0, 20'h0, '0,      1'b1, 1'b0, 1'b1, line_init(15)};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_mem_ldp", {127'd0, mem_ldp}, 128'd0);
        chk("rst_mem_srp", {127'd0, mem_srp}, 128'd0);
        chk("rst_mem_addr", {108'd0, mem_addr}, 128'd0);
        chk("rst_mem_srData", mem_srData, 128'd0);
        chk("rst_ready", {126'd0, ic_ready, dc_ready}, 128'd0);
        chk("rst_ic_data", ic_data, 128'd0);
        chk("rst_dc_ldData", dc_ldData, 128'd0);

        // Conflicts from reset alternate DC, IC, DC.
        for (int k = 0; k < 3; k++) begin
            do_txn(1, 1, 0, 20'h00030, 20'h00060, '0, 1, g_ic, g_dc, rdat, lat, stb, r1);
            chk($sformatf("conf%0d_ready", k), {126'd0, g_ic, g_dc},
                (k == 1) ? 128'd2 : 128'd1);
            chk($sformatf("conf%0d_data", k), rdat, (k == 1) ? line_init(3) : line_init(6));
            chk($sformatf("conf%0d_lat", k), 128'(lat), 128'd10);
        end

        for (int i = 0; i < 6; i++) begin
            acc0 = accesses;
            do_txn(vecs[i].ic, vecs[i].ld, vecs[i].st, vecs[i].a_ic, vecs[i].a_dc, vecs[i].wd,
                   1, g_ic, g_dc, rdat, lat, stb, r1);
            chk($sformatf("vec%0d_ready", i), {126'd0, g_ic, g_dc},
                {126'd0, vecs[i].e_ic, vecs[i].e_dc});
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd10);
            chk($sformatf("vec%0d_req1", i), {127'd0, r1}, 128'd1);
            chk($sformatf("vec%0d_stable", i), {127'd0, stb}, 128'd1);
            chk($sformatf("vec%0d_accesses", i), 128'(accesses - acc0), 128'd1);
            if (vecs[i].chk_d) begin
                chk($sformatf("vec%0d_data", i), rdat, vecs[i].ed);
                chk($sformatf("vec%0d_hold", i), vecs[i].ic ? ic_data : dc_ldData, vecs[i].ed);
            end
        end
        chk("store_committed", mem_line[2], STORE_D);

        // Request held through RESP must not be regranted.
        acc0 = accesses;
        do_txn(1, 0, 0, 20'h00010, 20'h0, '0, 0, g_ic, g_dc, rdat, lat, stb, r1);
        ic_req = 0;
        chk("hold_ready", {126'd0, g_ic, g_dc}, 128'd2);
        seen_rdy = 0; seen_req = 0;
        repeat (15) begin
            step();
            if (ic_ready || dc_ready) seen_rdy++;
            if (mem_ldp || mem_srp) seen_req++;
        end
        chk("hold_no_regrant", 128'(seen_req), 128'd0);
        chk("hold_no_ready", 128'(seen_rdy), 128'd0);
        chk("hold_one_access", 128'(accesses - acc0), 128'd1);

        // Reset 4 cycles into a store.
        dc_srp = 1; dc_addr = 20'h00040; dc_srData = STORE_X;
        step();
        chk("rstmid_srp_up", {127'd0, mem_srp}, 128'd1);
        repeat (4) step();
        rst = 1;
        step();
        rst = 0; dc_srp = 0;
        chk("rstmid_srp_low", {127'd0, mem_srp}, 128'd0);
        chk("rstmid_no_ready", {126'd0, ic_ready, dc_ready}, 128'd0);
        seen_rdy = 0; seen_req = 0;
        repeat (15) begin
            step();
            if (ic_ready || dc_ready) seen_rdy++;
            if (mem_ldp || mem_srp) seen_req++;
        end
        chk("rstmid_idle_quiet", 128'(seen_rdy + seen_req), 128'd0);
        chk("rstmid_line_kept", mem_line[4], line_init(4));
        do_txn(0, 1, 0, 20'h0, 20'h00040, '0, 1, g_ic, g_dc, rdat, lat, stb, r1);
        chk("rstmid_reload", rdat, line_init(4));
        chk("rstmid_reload_lat", 128'(lat), 128'd10);

        // Spurious load ack while idle.
        inj_ldr = 1;
        step();
        inj_ldr = 0;
        seen_rdy = 0; seen_req = 0;
        repeat (5) begin
            step();
            if (ic_ready || dc_ready) seen_rdy++;
            if (mem_ldp || mem_srp) seen_req++;
        end
        chk("spur_no_ready", 128'(seen_rdy), 128'd0);
        chk("spur_no_req", 128'(seen_req), 128'd0);
        do_txn(1, 0, 0, 20'h00010, 20'h0, '0, 1, g_ic, g_dc, rdat, lat, stb, r1);
        chk("spur_after_ready", {126'd0, g_ic, g_dc}, 128'd2);
        chk("spur_after_data", rdat, line_init(1));
        chk("spur_after_lat", 128'(lat), 128'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
